// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the PE-array operand feeder:
//   - DATA_WIDTH_DEF / DIM_DEF : default element width and array dimension
//   - state_e                  : feeder sequencing states
//   - flush_cycles()           : cycles needed to drain the skewed wavefront
//   - FLUSH_CYCLES             : flush_cycles() evaluated for DIM_DEF
// No ports (package).
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int DIM_DEF        = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STREAM = 3'd1,
      FLUSH  = 3'd2,
      HOLD   = 3'd3,
      CLEAR  = 3'd4
   } state_e;

   // The last operand needs DIM-1 skew cycles plus DIM-1 hops to reach
   // PE(DIM-1, DIM-1), plus one edge for that PE to accumulate it.
   function automatic int flush_cycles(input int dim);
      return 2 * dim - 1;
   endfunction

   localparam int FLUSH_CYCLES = flush_cycles(DIM_DEF);

endpackage

// File: rtl/skew_lane.sv
// -----------------------------------------------------------------------------
// skew_lane
// DEPTH-stage register chain used to delay one operand lane.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous, active-high reset (clears every stage)
//   d_i     : lane input, captured by stage 1
//   q_o     : output of the last stage (registered)
// -----------------------------------------------------------------------------
module skew_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] d_i,
   output logic [DATA_WIDTH-1:0] q_o
);

   logic [DATA_WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         for (int s = 0; s < DEPTH; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int s = 1; s < DEPTH; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_edge_feeder.sv
// -----------------------------------------------------------------------------
// systolic_edge_feeder
// Transmit side of the PE-array operand interface. Accepts one A column and
// one B row per beat and emits them as skewed, zero-filled wavefronts on the
// west and north edges of a DIM x DIM array, then sequences the end of each
// product: FLUSH -> HOLD (res_valid_o) -> CLEAR (one-cycle clr_o) -> IDLE.
//
// Handshake: a beat is accepted on a rising clk_i edge where
// in_valid_i && in_ready_o; in_last_i is only looked at on that beat.
// There is no backpressure toward the array; both edges always advance.
//
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-high reset
//   a_col_i, b_row_i       : DIM lanes of DATA_WIDTH, lane i at [i*DW +: DW]
//   in_valid_i, in_last_i  : beat valid / final k-step of the product
//   in_ready_o             : high in IDLE and STREAM (decoded from state)
//   west_o, north_o        : skewed edge operands (registered)
//   clr_o                  : one-cycle clear pulse to all PEs (registered)
//   res_valid_o            : array results are final (registered)
//   res_ack_i              : consumer captured the results (used in HOLD only)
//   busy_o                 : state != IDLE (decoded from state)
//   k_cnt_o                : accepted-beat count, saturating; only present
//                            when FEEDER_KCNT_EN is defined
// -----------------------------------------------------------------------------
module systolic_edge_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DIM        = DIM_DEF,
   parameter int KCNT_WIDTH = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [DIM*DATA_WIDTH-1:0] a_col_i,
   input  logic [DIM*DATA_WIDTH-1:0] b_row_i,
   input  logic                      in_valid_i,
   input  logic                      in_last_i,
   output logic                      in_ready_o,
   output logic [DIM*DATA_WIDTH-1:0] west_o,
   output logic [DIM*DATA_WIDTH-1:0] north_o,
   output logic                      clr_o,
   output logic                      res_valid_o,
   input  logic                      res_ack_i,
   output logic                      busy_o
`ifdef FEEDER_KCNT_EN
   ,
   output logic [KCNT_WIDTH-1:0]     k_cnt_o
`endif
);

   localparam int FC = flush_cycles(DIM);
   localparam int CW = $clog2(FC + 1);

   if (DIM < 2) begin : g_bad_dim
      $error("systolic_edge_feeder: DIM must be >= 2");
   end
   if (KCNT_WIDTH < 1) begin : g_bad_kcnt
      $error("systolic_edge_feeder: KCNT_WIDTH must be >= 1");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
   logic            res_valid_q, clr_q;
   logic            accept;
   logic [DIM*DATA_WIDTH-1:0] a_inj, b_inj;

   assign in_ready_o = (state_q == IDLE) || (state_q == STREAM);
   assign busy_o     = (state_q != IDLE);
   assign accept     = in_valid_i && in_ready_o;

   // Non-accept cycles inject zeros: 0*x contributes nothing to the PEs.
   assign a_inj = accept ? a_col_i : '0;
   assign b_inj = accept ? b_row_i : '0;

   for (genvar i = 0; i < DIM; i++) begin : g_lane
      skew_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (i + 1)
      ) u_west (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .d_i    (a_inj[i*DATA_WIDTH +: DATA_WIDTH]),
         .q_o    (west_o[i*DATA_WIDTH +: DATA_WIDTH])
      );
      skew_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (i + 1)
      ) u_north (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .d_i    (b_inj[i*DATA_WIDTH +: DATA_WIDTH]),
         .q_o    (north_o[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         IDLE, STREAM: begin
            if (accept) begin
               if (in_last_i) begin
                  state_d     = FLUSH;
                  flush_cnt_d = CW'(FC);
               end else begin
                  state_d = STREAM;
               end
            end
         end
         FLUSH: begin
            // Leave when the counter reaches zero, so FLUSH spans FC cycles.
            flush_cnt_d = flush_cnt_q - 1'b1;
            if (flush_cnt_q == CW'(1)) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (res_ack_i) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // res_valid_o / clr_o are registered copies of the next-state decode so
   // they line up with the state register and can never overlap.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         res_valid_q <= 1'b0;
         clr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         res_valid_q <= (state_d == HOLD);
         clr_q       <= (state_d == CLEAR);
      end
   end

   assign res_valid_o = res_valid_q;
   assign clr_o       = clr_q;

`ifdef FEEDER_KCNT_EN
   logic [KCNT_WIDTH-1:0] k_cnt_q, k_cnt_d;

   always_comb begin
      k_cnt_d = k_cnt_q;
      if (state_q == CLEAR) begin
         k_cnt_d = '0;
      end else if (accept && (k_cnt_q != '1)) begin
         k_cnt_d = k_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         k_cnt_q <= '0;
      end else begin
         k_cnt_q <= k_cnt_d;
      end
   end

   assign k_cnt_o = k_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_edge_feeder
// Directed bench for systolic_edge_feeder (DIM=4, DATA_WIDTH=8). A behavioural
// 4x4 PE array is driven from west_o/north_o so full products can be checked
// against hand-computed matrix results.
// -----------------------------------------------------------------------------
module tb_systolic_edge_feeder;

   localparam int DIM = 4;
   localparam int DW  = 8;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [DIM*DW-1:0] a_col_i, b_row_i;
   logic              in_valid_i, in_last_i;
   logic              in_ready_o;
   logic [DIM*DW-1:0] west_o, north_o;
   logic              clr_o, res_valid_o;
   logic              res_ack_i;
   logic              busy_o;
   logic [15:0]       k_cnt_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   systolic_edge_feeder #(.DATA_WIDTH(DW), .DIM(DIM), .KCNT_WIDTH(16)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .a_col_i     (a_col_i),
      .b_row_i     (b_row_i),
      .in_valid_i  (in_valid_i),
      .in_last_i   (in_last_i),
      .in_ready_o  (in_ready_o),
      .west_o      (west_o),
      .north_o     (north_o),
      .clr_o       (clr_o),
      .res_valid_o (res_valid_o),
      .res_ack_i   (res_ack_i),
      .busy_o      (busy_o)
`ifdef FEEDER_KCNT_EN
      ,
      .k_cnt_o     (k_cnt_o)
`endif
   );

`ifndef FEEDER_KCNT_EN
   assign k_cnt_o = '0;
`endif

   // ---------------- clock / watchdog ----------------
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural PE array ----------------
   int                acc   [DIM][DIM];
   logic signed [7:0] w_reg [DIM][DIM];
   logic signed [7:0] n_reg [DIM][DIM];

   function automatic logic signed [7:0] w_in(input int r, input int c);
      if (c == 0) return $signed(west_o[r*DW +: DW]);
      return w_reg[r][c-1];
   endfunction

   function automatic logic signed [7:0] n_in(input int r, input int c);
      if (r == 0) return $signed(north_o[c*DW +: DW]);
      return n_reg[r-1][c];
   endfunction

   always @(posedge clk_i) begin
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            if (rst_ni || clr_o) begin
               acc[r][c]   <= 0;
               w_reg[r][c] <= '0;
               n_reg[r][c] <= '0;
            end else begin
               acc[r][c]   <= acc[r][c] + int'(w_in(r, c)) * int'(n_in(r, c));
               w_reg[r][c] <= w_in(r, c);
               n_reg[r][c] <= n_in(r, c);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      res_ack_i  = 1'b0;
      a_col_i    = '0;
      b_row_i    = '0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        vld, lst, ack;
      logic [31:0] a, b;
      logic [31:0] ew, en;
      logic        er, eb, erv, eclr;
   } vec_t;

   vec_t vt [16];

   // ---------------- product sequence ----------------
   logic [31:0] mat_a [4];
   logic [31:0] mat_b [4];

   task automatic run_product(input int k, input int gap_at, input int gap_len,
                              input logic ack_early, input string tag);
      int cyc;
      int expv;
      res_ack_i = ack_early;
      for (int bt = 0; bt < k; bt++) begin
         if (bt == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               in_valid_i = 1'b0;
               in_last_i  = 1'b0;
               a_col_i    = 32'hDEADBEEF;
               b_row_i    = 32'hCAFEF00D;
               step();
               check({tag, "_gap_west0"}, {24'h0, west_o[7:0]}, 32'h0);
               check({tag, "_gap_north0"}, {24'h0, north_o[7:0]}, 32'h0);
            end
         end
         a_col_i    = mat_a[bt];
         b_row_i    = mat_b[bt];
         in_valid_i = 1'b1;
         in_last_i  = (bt == k - 1);
         step();
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      check({tag, "_flush_ready"}, {31'h0, in_ready_o}, 32'h0);
      check({tag, "_flush_busy"}, {31'h0, busy_o}, 32'h1);
      cyc = 1;
      while (res_valid_o !== 1'b1 && cyc < 64) begin
         check({tag, "_flush_not_in"}, {31'h0, in_ready_o}, 32'h0);
         in_valid_i = 1'b1;  // must be ignored during FLUSH
         step();
         in_valid_i = 1'b0;
         cyc++;
      end
      check({tag, "_flush_len"}, cyc - 1, 32'd7);
      check({tag, "_hold_clr_low"}, {31'h0, clr_o}, 32'h0);
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            expv = 0;
            for (int bt = 0; bt < k; bt++) begin
               expv += int'($signed(mat_a[bt][r*DW +: DW])) * int'($signed(mat_b[bt][c*DW +: DW]));
            end
            check($sformatf("%s_res_%0d_%0d", tag, r, c), acc[r][c], expv);
         end
      end
      if (!ack_early) begin
         in_valid_i = 1'b1;
         step();
         in_valid_i = 1'b0;
         check({tag, "_hold_stays"}, {31'h0, res_valid_o}, 32'h1);
         check({tag, "_hold_no_accept"}, {31'h0, in_ready_o}, 32'h0);
         res_ack_i = 1'b1;
      end
      step();
      res_ack_i = 1'b0;
      check({tag, "_clr_pulse"}, {31'h0, clr_o}, 32'h1);
      check({tag, "_clr_rv_low"}, {31'h0, res_valid_o}, 32'h0);
      step();
      check({tag, "_clr_once"}, {31'h0, clr_o}, 32'h0);
      check({tag, "_idle_busy"}, {31'h0, busy_o}, 32'h0);
      check({tag, "_idle_ready"}, {31'h0, in_ready_o}, 32'h1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      //             vld   lst   ack   a             b             ew            en            er    eb    erv   eclr
      vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h04030201, 32'h08070605, 32'h00000001, 32'h00000005, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000200, 32'h00000600, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00030000, 32'h00070000, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h04000000, 32'h08000000, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h55555555, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h7F80FF01, 32'h11223344, 32'h00000001, 32'h00000044, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b1, 1'b0, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0000FF00, 32'h00003300, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00800000, 32'h00220000, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h7F000000, 32'h11000000, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
      vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
      vt[14] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1};
      vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0};

      // reset state
      idle_inputs();
      rst_ni = 1'b1;
      step();
      step();
      check("rst_west", west_o, 32'h0);
      check("rst_north", north_o, 32'h0);
      check("rst_ready", {31'h0, in_ready_o}, 32'h1);
      check("rst_busy", {31'h0, busy_o}, 32'h0);
      check("rst_res_valid", {31'h0, res_valid_o}, 32'h0);
      check("rst_clr", {31'h0, clr_o}, 32'h0);
      rst_ni = 1'b0;
      step();
      check("post_rst_clr", {31'h0, clr_o}, 32'h0);

      // skew timing, FLUSH ignore, HOLD/CLEAR via table
      for (int i = 0; i < 16; i++) begin
         in_valid_i = vt[i].vld;
         in_last_i  = vt[i].lst;
         res_ack_i  = vt[i].ack;
         a_col_i    = vt[i].a;
         b_row_i    = vt[i].b;
         step();
         check($sformatf("vec%0d_west", i), west_o, vt[i].ew);
         check($sformatf("vec%0d_north", i), north_o, vt[i].en);
         check($sformatf("vec%0d_ready", i), {31'h0, in_ready_o}, {31'h0, vt[i].er});
         check($sformatf("vec%0d_busy", i), {31'h0, busy_o}, {31'h0, vt[i].eb});
         check($sformatf("vec%0d_res_valid", i), {31'h0, res_valid_o}, {31'h0, vt[i].erv});
         check($sformatf("vec%0d_clr", i), {31'h0, clr_o}, {31'h0, vt[i].eclr});
      end
      idle_inputs();
      step();

      // identity product
      for (int bt = 0; bt < 4; bt++) begin
         mat_a[bt] = 32'h1 << (8 * bt);
         mat_b[bt] = 32'h1 << (8 * bt);
      end
      run_product(4, -1, 0, 1'b0, "ident");

      // same product with a 2-cycle bubble between beats 2 and 3
      run_product(4, 2, 2, 1'b0, "bubble");

      // K = 1 with negative operands, ack held high before HOLD
      mat_a[0] = 32'hFFFFFFFF;
      mat_b[0] = 32'h7F7F7F7F;
      run_product(1, -1, 0, 1'b1, "k1neg");

      // reset in the middle of a stream
      in_valid_i = 1'b1;
      a_col_i    = 32'h01020304;
      b_row_i    = 32'h05060708;
      step();
      a_col_i    = 32'h11121314;
      b_row_i    = 32'h15161718;
      step();
      in_valid_i = 1'b0;
      rst_ni     = 1'b1;
      step();
      rst_ni = 1'b0;
      check("mrst_west", west_o, 32'h0);
      check("mrst_north", north_o, 32'h0);
      check("mrst_clr", {31'h0, clr_o}, 32'h0);
      check("mrst_ready", {31'h0, in_ready_o}, 32'h1);
      check("mrst_busy", {31'h0, busy_o}, 32'h0);
      step();
      check("mrst_clr_after", {31'h0, clr_o}, 32'h0);
      check("mrst_west_after", west_o, 32'h0);

      // clean identity product after the mid-stream reset
      for (int bt = 0; bt < 4; bt++) begin
         mat_a[bt] = 32'h1 << (8 * bt);
         mat_b[bt] = 32'h1 << (8 * bt);
      end
      run_product(4, -1, 0, 1'b0, "after_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
